// File: rtl/mlp_eval_pkg.sv
// Shared types and default sizes for the printed-MLP evaluation sequencer.
package mlp_eval_pkg;

    localparam int NUM_A_DEF    = 4;
    localparam int WIDTH_A_DEF  = 4;
    localparam int OUTWIDTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESULT
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Sticks at all-ones so long campaigns never wrap back to a small count.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mlp_eval_sequencer.sv
// Drives one combinational MLP classifier from a sample stream, holds the
// features for a settle time, captures and scores the class, and keeps stats.
module mlp_eval_sequencer
    import mlp_eval_pkg::*;
#(
    parameter int NUM_A         = NUM_A_DEF,
    parameter int WIDTH_A       = WIDTH_A_DEF,
    parameter int OUTWIDTH      = OUTWIDTH_DEF,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_A*WIDTH_A-1:0] in_feat,
    input  logic [OUTWIDTH-1:0]      in_label,
    output logic [NUM_A*WIDTH_A-1:0] cls_inp,
    input  logic [OUTWIDTH-1:0]      cls_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [OUTWIDTH-1:0]      res_class,
    output logic                     res_match,
    input  logic                     stats_clr,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     busy
);

    localparam int FW  = NUM_A * WIDTH_A;
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
    localparam logic [SCW-1:0] SETTLE_ONE  = SCW'(1);

    state_e              state_d, state_q;
    logic [FW-1:0]       cls_inp_d, cls_inp_q;
    logic [OUTWIDTH-1:0] label_d, label_q;
    logic [SCW-1:0]      cnt_d, cnt_q;
    logic [OUTWIDTH-1:0] res_class_d, res_class_q;
    logic                res_match_d, res_match_q;
    logic                res_valid_d, res_valid_q;
    logic                res_hs;

    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign res_hs   = res_valid_q && res_ready;

    // The classifier is shared, so a new sample is only taken from IDLE and
    // cls_out is looked at solely on the final settle edge.
    always_comb begin
        state_d     = state_q;
        cls_inp_d   = cls_inp_q;
        label_d     = label_q;
        cnt_d       = cnt_q;
        res_class_d = res_class_q;
        res_match_d = res_match_q;
        res_valid_d = res_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    cls_inp_d = in_feat;
                    label_d   = in_label;
                    cnt_d     = SETTLE_LOAD;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    res_class_d = cls_out;
                    res_match_d = (cls_out == label_q);
                    res_valid_d = 1'b1;
                    state_d     = ST_RESULT;
                end else begin
                    cnt_d = cnt_q - SETTLE_ONE;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cls_inp_q   <= '0;
            label_q     <= '0;
            cnt_q       <= '0;
            res_class_q <= '0;
            res_match_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_inp_q   <= cls_inp_d;
            label_q     <= label_d;
            cnt_q       <= cnt_d;
            res_class_q <= res_class_d;
            res_match_q <= res_match_d;
            res_valid_q <= res_valid_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_sample_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (res_hs),
        .q   (sample_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (res_hs && !res_match_q),
        .q   (err_cnt)
    );

    assign cls_inp   = cls_inp_q;
    assign res_valid = res_valid_q;
    assign res_class = res_class_q;
    assign res_match = res_match_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mlp_eval_sequencer.sv
// Bench for mlp_eval_sequencer: a default instance (settle 8, 16-bit counters)
// and a fast instance (settle 1, 4-bit counters) for saturation and cadence.
module tb_mlp_eval_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, in_valid0, in_ready0, res_valid0, res_ready0, res_match0, stats_clr0, busy0;
    logic [15:0] in_feat0, cls_inp0, sample_cnt0, err_cnt0;
    logic [1:0]  in_label0, cls_out0, res_class0;

    logic        rst1, in_valid1, in_ready1, res_valid1, res_ready1, res_match1, stats_clr1, busy1;
    logic [15:0] in_feat1, cls_inp1;
    logic [3:0]  sample_cnt1, err_cnt1;
    logic [1:0]  in_label1, cls_out1, res_class1;

    int n_cmp = 0;
    int n_err = 0;

    int          stub_mode;
    logic [1:0]  stub_const;
    logic [1:0]  stub1;
    logic [1:0]  toggle_val = 2'd0;
    int          edge_cnt = 0;

    int m_samp;
    int m_err;

    typedef struct {
        logic [15:0] feat;
        logic [1:0]  label;
        logic [1:0]  stub;
        int          delay;
        logic [1:0]  exp_class;
        logic        exp_match;
    } vec_t;

    vec_t vecs[5];

    // Behavioural classifier: sum of all features, modulo the class count.
    function automatic logic [1:0] refClass(input logic [15:0] f);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'(f[i*4 +: 4]);
        return 2'(s % 4);
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) toggle_val <= edge_cnt[0] ? 2'd3 : 2'd0;

    always_comb begin
        cls_out0 = stub_const;
        if (stub_mode == 1) cls_out0 = toggle_val;
        else if (stub_mode == 2) cls_out0 = refClass(cls_inp0);
    end
    assign cls_out1 = stub1;

    mlp_eval_sequencer #(.SETTLE_CYCLES(8), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_feat(in_feat0), .in_label(in_label0), .cls_inp(cls_inp0), .cls_out(cls_out0),
        .res_valid(res_valid0), .res_ready(res_ready0), .res_class(res_class0),
        .res_match(res_match0), .stats_clr(stats_clr0), .sample_cnt(sample_cnt0),
        .err_cnt(err_cnt0), .busy(busy0)
    );

    mlp_eval_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_feat(in_feat1), .in_label(in_label1), .cls_inp(cls_inp1), .cls_out(cls_out1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_class(res_class1),
        .res_match(res_match1), .stats_clr(stats_clr1), .sample_cnt(sample_cnt1),
        .err_cnt(err_cnt1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offers one sample to dut0 and returns the edge index at which it was taken.
    task automatic applyStimulus(input logic [15:0] feat, input logic [1:0] label, output int acc_edge);
        int t;
        t = 0;
        in_feat0  = feat;
        in_label0 = label;
        in_valid0 = 1'b1;
        while (!in_ready0 && t < 30) begin
            tick();
            t++;
        end
        if (t >= 30) checkOutput("accept_timeout", 32'd1, 32'd0);
        tick();
        in_valid0 = 1'b0;
        acc_edge  = edge_cnt;
    endtask

    task automatic waitResult0(output int lat);
        lat = 0;
        while (!res_valid0 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finishResult0(input logic exp_match);
        res_ready0 = 1'b1;
        tick();
        res_ready0 = 1'b0;
        if (m_samp < 65535) m_samp++;
        if (!exp_match && m_err < 65535) m_err++;
        checkOutput("res_valid_drop", 32'(res_valid0), 32'd0);
        checkOutput("sample_cnt", 32'(sample_cnt0), 32'(m_samp));
        checkOutput("err_cnt", 32'(err_cnt0), 32'(m_err));
    endtask

    task automatic runSample0(input logic [15:0] feat, input logic [1:0] label,
                              input logic [1:0] exp_class, input logic exp_match, input int delay);
        int acc;
        int lat;
        res_ready0 = 1'b0;
        applyStimulus(feat, label, acc);
        checkOutput("cls_inp_latched", 32'(cls_inp0), 32'(feat));
        waitResult0(lat);
        checkOutput("latency", 32'(lat), 32'd8);
        checkOutput("res_class", 32'(res_class0), 32'(exp_class));
        checkOutput("res_match", 32'(res_match0), 32'(exp_match));
        for (int i = 0; i < delay; i++) begin
            tick();
            checkOutput("hold_valid", 32'(res_valid0), 32'd1);
            checkOutput("hold_class", 32'(res_class0), 32'(exp_class));
            checkOutput("hold_match", 32'(res_match0), 32'(exp_match));
            checkOutput("hold_in_ready", 32'(in_ready0), 32'd0);
        end
        finishResult0(exp_match);
        checkOutput("cls_inp_kept", 32'(cls_inp0), 32'(feat));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc;
        int lat;
        int accepts;
        int seen;
        logic [15:0] rf;
        logic [1:0]  rl;
        logic [1:0]  rc;
        logic [1:0]  exp_t;

        vecs[0] = '{16'h9173, 2'd1, 2'd1, 0, 2'd1, 1'b1};
        vecs[1] = '{16'h9173, 2'd2, 2'd1, 5, 2'd1, 1'b0};
        vecs[2] = '{16'h0000, 2'd0, 2'd0, 2, 2'd0, 1'b1};
        vecs[3] = '{16'hffff, 2'd3, 2'd2, 1, 2'd2, 1'b0};
        vecs[4] = '{16'ha5c3, 2'd3, 2'd3, 3, 2'd3, 1'b1};

        stub_mode = 0; stub_const = 2'd1; stub1 = 2'd0;
        rst0 = 1'b1; in_valid0 = 1'b0; in_feat0 = '0; in_label0 = '0; res_ready0 = 1'b0; stats_clr0 = 1'b0;
        rst1 = 1'b1; in_valid1 = 1'b0; in_feat1 = '0; in_label1 = '0; res_ready1 = 1'b0; stats_clr1 = 1'b0;
        m_samp = 0; m_err = 0;

        tick();
        checkOutput("in_ready_in_reset", 32'(in_ready0), 32'd0);
        tick();
        checkOutput("rst_cls_inp", 32'(cls_inp0), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid0), 32'd0);
        checkOutput("rst_sample_cnt", 32'(sample_cnt0), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt0), 32'd0);
        checkOutput("rst_busy", 32'(busy0), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick();
        checkOutput("idle_in_ready", 32'(in_ready0), 32'd1);

        // Table-driven constant-stub samples.
        for (int v = 0; v < 5; v++) begin
            stub_const = vecs[v].stub;
            runSample0(vecs[v].feat, vecs[v].label, vecs[v].exp_class, vecs[v].exp_match, vecs[v].delay);
            tick();
        end

        // Toggling classifier output: only the value at edge k+8 may be captured.
        stub_mode = 1;
        res_ready0 = 1'b0;
        applyStimulus(16'h1234, 2'd0, acc);
        exp_t = (((acc + 7) % 2) == 1) ? 2'd3 : 2'd0;
        waitResult0(lat);
        checkOutput("toggle_latency", 32'(lat), 32'd8);
        checkOutput("toggle_capture", 32'(res_class0), 32'(exp_t));
        finishResult0(exp_t == 2'd0);
        tick();

        // Reset mid-settle discards the sample.
        stub_mode = 0; stub_const = 2'd1;
        applyStimulus(16'h4242, 2'd1, acc);
        tick(); tick(); tick();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        m_samp = 0; m_err = 0;
        checkOutput("midrst_busy", 32'(busy0), 32'd0);
        checkOutput("midrst_cls_inp", 32'(cls_inp0), 32'd0);
        checkOutput("midrst_sample_cnt", 32'(sample_cnt0), 32'd0);
        checkOutput("midrst_err_cnt", 32'(err_cnt0), 32'd0);
        res_ready0 = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (res_valid0) seen++;
            tick();
        end
        res_ready0 = 1'b0;
        checkOutput("midrst_no_result", 32'(seen), 32'd0);
        checkOutput("midrst_counts_zero", 32'(sample_cnt0), 32'd0);
        runSample0(16'h9173, 2'd1, 2'd1, 1'b1, 0);
        tick();

        // Randomized samples against the behavioural classifier model.
        stub_mode = 2;
        for (int r = 0; r < 12; r++) begin
            rf = 16'($urandom);
            rl = 2'($urandom_range(0, 3));
            rc = refClass(rf);
            runSample0(rf, rl, rc, rc == rl, int'($urandom_range(0, 3)));
        end

        // Stats clear does not disturb the FSM.
        stats_clr0 = 1'b1;
        tick();
        stats_clr0 = 1'b0;
        m_samp = 0; m_err = 0;
        checkOutput("clr_sample_cnt", 32'(sample_cnt0), 32'd0);
        checkOutput("clr_err_cnt", 32'(err_cnt0), 32'd0);
        checkOutput("clr_in_ready", 32'(in_ready0), 32'd1);

        // Fast instance: one-cycle settle.
        stub1 = 2'd0;
        in_feat1 = 16'h0f0f; in_label1 = 2'd0; in_valid1 = 1'b1;
        checkOutput("fast_in_ready", 32'(in_ready1), 32'd1);
        tick();
        in_valid1 = 1'b0;
        checkOutput("fast_settling", 32'(res_valid1), 32'd0);
        tick();
        checkOutput("fast_res_valid", 32'(res_valid1), 32'd1);
        checkOutput("fast_match", 32'(res_match1), 32'd1);
        res_ready1 = 1'b1;
        tick();
        checkOutput("fast_sample_cnt", 32'(sample_cnt1), 32'd1);

        // Continuous offers: one accept every three cycles, counters saturate.
        in_label1 = 2'd1; in_valid1 = 1'b1;
        accepts = 0;
        for (int i = 0; i < 60; i++) begin
            if (in_ready1) accepts++;
            tick();
        end
        in_valid1 = 1'b0;
        tick();
        checkOutput("cadence_accepts", 32'(accepts), 32'd20);
        checkOutput("sat_sample_cnt", 32'(sample_cnt1), 32'd15);
        checkOutput("sat_err_cnt", 32'(err_cnt1), 32'd15);

        // Clear coinciding with a result handshake wins.
        res_ready1 = 1'b0;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        while (!res_valid1 && lat < 10) begin
            tick();
            lat++;
        end
        checkOutput("clr_hs_valid", 32'(res_valid1), 32'd1);
        res_ready1 = 1'b1; stats_clr1 = 1'b1;
        tick();
        res_ready1 = 1'b0; stats_clr1 = 1'b0;
        checkOutput("clr_hs_sample", 32'(sample_cnt1), 32'd0);
        checkOutput("clr_hs_err", 32'(err_cnt1), 32'd0);
        checkOutput("clr_hs_done", 32'(res_valid1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
